// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode display.
//
// Each digit owns a slot of CLK_DIV cycles. The first BLANK_CYCLES cycles of a slot keep
// every anode off. During that time the new digit nibble is already driven, so the
// downstream registered segment decoder has settled before the anode turns on.
// A new value is loaded into a pending register. It becomes the displayed (active) value
// only at a frame boundary, so a frame never shows a mix of old and new digits.
//
// Ports
//   clkIn     clock
//   rstIn     asynchronous, active-high reset
//   loadIn    single-cycle request to capture valueIn as the pending value
//   valueIn   four hex nibbles, digit 0 = [3:0] .. digit 3 = [15:12]
//   enIn      per-digit enable, 0 keeps that digit dark (sampled every cycle)
//   digitOut  nibble for the current slot, to the segment decoder
//   anodeOut  active-low digit select
//   busyOut   a loaded value is pending and not yet displayed
//   ackOut    one-cycle pulse when the pending value becomes active
//   frameOut  one-cycle pulse at each frame start
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        loadIn,
  input  logic [15:0] valueIn,
  input  logic [3:0]  enIn,
  output logic [3:0]  digitOut,
  output logic [3:0]  anodeOut,
  output logic        busyOut,
  output logic        ackOut,
  output logic        frameOut
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

  typedef enum logic {StBlank, StShow} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     pending_q, pending_d;
  logic [15:0]     active_q, active_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic            frame_q, frame_d;
  logic [3:0]      anode_q, anode_d;
  logic [3:0]      digit_q, digit_d;
  logic            frame_edge;

  // Last cycle of slot 3: the clock edge that ends this cycle starts a new frame.
  assign frame_edge = (cnt_q == CntMax) && (idx_q == 2'd3);

  // Slot counter and slot index.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Pending/active double buffer. At a coincident load and boundary, the old pending
  // value moves to active and the new value becomes pending.
  always_comb begin
    pending_d = pending_q;
    active_d  = active_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    frame_d   = frame_edge;
    if (frame_edge && busy_q) begin
      active_d = pending_q;
      busy_d   = 1'b0;
      ack_d    = 1'b1;
    end
    if (loadIn) begin
      pending_d = valueIn;
      busy_d    = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q <= StBlank;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. It follows the counter value being loaded, so the state always
  // matches cnt_q.
  always_comb begin
    state_d = (cnt_d < CntBlank) ? StBlank : StShow;
  end

  // FSM outputs. These are computed from next-state values, so the registered
  // outputs line up with the registered cnt_q and idx_q.
  always_comb begin
    anode_d = 4'hF;
    if ((state_d == StShow) && enIn[idx_d]) begin
      anode_d[idx_d] = 1'b0;
    end
    digit_d = active_d[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      pending_q <= 16'h0000;
      active_q  <= 16'h0000;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      frame_q   <= 1'b0;
      anode_q   <= 4'hF;
      digit_q   <= 4'h0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      frame_q   <= frame_d;
      anode_q   <= anode_d;
      digit_q   <= digit_d;
    end
  end

  assign digitOut = digit_q;
  assign anodeOut = anode_q;
  assign busyOut  = busy_q;
  assign ackOut   = ack_q;
  assign frameOut = frame_q;

endmodule
